puf_challenge_ctrl: RTL and testbench

PUF_CHALLENGE_CTRL -- requirements
Module: puf_challenge_ctrl

---
 rtl/puf_challenge_ctrl.sv | 155 +++++++++++++++
 tb/tb_puf_challenge_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_ctrl.sv
// Arbiter-PUF challenge sequencer: an LFSR drives the mux chain through precharge/race/sample
// phases and shifts one arbiter decision per round into the response word.
module puf_challenge_ctrl #(
  parameter int unsigned CHAL_W = 32,
  parameter int unsigned RESP_W = 16,
  parameter int unsigned SETTLE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] seed,
  input  logic              arb_out,
  output logic [CHAL_W-1:0] challenge,
  output logic              launch,
  output logic              busy,
  output logic [RESP_W-1:0] response,
  output logic              resp_valid,
  input  logic              resp_ack
);

  localparam int unsigned BitW = $clog2(RESP_W + 1);
  // Middle tap sits at bit 21 for the 32-bit polynomial; narrower chains fall back to the midpoint.
  localparam int unsigned TapB = (CHAL_W > 22) ? 21 : CHAL_W / 2;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StPre    = 3'd2;
  localparam logic [2:0] StRace   = 3'd3;
  localparam logic [2:0] StSample = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [CHAL_W-1:0] lfsr_q, lfsr_d;
  logic [CHAL_W-1:0] challenge_q, challenge_d;
  logic [RESP_W-1:0] response_q, response_d;
  logic              launch_q, launch_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;

  logic [CHAL_W-1:0] lfsr_step;
  logic [CHAL_W-1:0] seed_fixed;
  logic              phase_end;
  logic              in_run;

  assign lfsr_step  = {lfsr_q[CHAL_W-2:0],
                       lfsr_q[CHAL_W-1] ^ lfsr_q[TapB] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign seed_fixed = (seed == '0) ? CHAL_W'(1) : seed;
  assign phase_end  = (cnt_q == 8'(SETTLE - 1));
  assign in_run     = (state_q == StLoad) || (state_q == StPre) ||
                      (state_q == StRace) || (state_q == StSample);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    lfsr_d      = lfsr_q;
    challenge_d = challenge_q;
    response_d  = response_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          lfsr_d      = seed_fixed;
          challenge_d = seed_fixed;
          bit_d       = '0;
          cnt_d       = '0;
          response_d  = '0;
        end
      end
      StLoad: begin
        state_d = StPre;
        cnt_d   = '0;
      end
      StPre: begin
        if (phase_end) begin
          state_d = StRace;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRace: begin
        if (phase_end) begin
          state_d = StSample;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSample: begin
        // First decision shifts all the way up to the MSB by the end of the run.
        response_d  = (response_q << 1) | RESP_W'(arb_out);
        lfsr_d      = lfsr_step;
        challenge_d = lfsr_step;
        bit_d       = bit_q + BitW'(1);
        cnt_d       = '0;
        state_d     = (bit_q == BitW'(RESP_W - 1)) ? StDone : StPre;
      end
      StDone: begin
        if (resp_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && in_run) begin
      state_d     = StIdle;
      cnt_d       = '0;
      bit_d       = '0;
      lfsr_d      = lfsr_q;
      challenge_d = challenge_q;
      response_d  = response_q;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    launch_d     = (state_d == StRace);
    busy_d       = (state_d != StIdle) && (state_d != StDone);
    resp_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      lfsr_q       <= CHAL_W'(1);
      challenge_q  <= '0;
      response_q   <= '0;
      launch_q     <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      lfsr_q       <= lfsr_d;
      challenge_q  <= challenge_d;
      response_q   <= response_d;
      launch_q     <= launch_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign challenge  = challenge_q;
  assign launch     = launch_q;
  assign busy       = busy_q;
  assign response   = response_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Scoreboard bench for puf_challenge_ctrl: a reference model predicts challenges, responses and
// latency per run; an independent monitor compares whatever the DUT presents.
module tb_puf_challenge_ctrl;

  localparam int CW  = 32;
  localparam int RW  = 16;
  localparam int ST  = 8;
  localparam int LAT = 1 + RW * (2 * ST + 1);

  logic          clk = 1'b0;
  logic          rst, start, abort, resp_ack, arb_out;
  logic [CW-1:0] seed, challenge;
  logic          launch, busy, resp_valid;
  logic [RW-1:0] response;

  int            arb_mode;
  logic [CW-1:0] arb_mask;

  typedef struct {
    logic [RW-1:0] resp;
    int            acc_cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [CW-1:0] chal_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;

  puf_challenge_ctrl #(.CHAL_W(CW), .RESP_W(RW), .SETTLE(ST)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .arb_out    (arb_out),
    .challenge  (challenge),
    .launch     (launch),
    .busy       (busy),
    .response   (response),
    .resp_valid (resp_valid),
    .resp_ack   (resp_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Idealised arbiter: a fixed function of the applied challenge.
  function automatic logic arb_fn(input logic [CW-1:0] c, input int mode, input logic [CW-1:0] m);
    case (mode)
      0:       return 1'b1;
      1:       return c[0];
      default: return ^(c & m);
    endcase
  endfunction

  assign arb_out = arb_fn(challenge, arb_mode, arb_mask);

  function automatic logic [CW-1:0] next_lfsr(input logic [CW-1:0] c);
    return (c << 1) | CW'(c[31] ^ c[21] ^ c[1] ^ c[0]);
  endfunction

  function automatic logic [RW-1:0] model_resp(input logic [CW-1:0] s, input int mode,
                                               input logic [CW-1:0] m);
    logic [CW-1:0] c;
    logic [RW-1:0] r;
    c = (s == 0) ? 1 : s;
    r = '0;
    for (int i = 0; i < RW; i++) begin
      r = (r << 1) | RW'(arb_fn(c, mode, m));
      c = next_lfsr(c);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Issue a start at the next edge and post the model's prediction to the scoreboard.
  task automatic do_start(input logic [CW-1:0] s, input int mode, input logic [CW-1:0] m);
    logic [CW-1:0] c;
    exp_t e;
    @(negedge clk);
    arb_mode = mode;
    arb_mask = m;
    seed     = s;
    start    = 1'b1;
    c = (s == 0) ? 1 : s;
    for (int i = 0; i < RW; i++) begin
      chal_q.push_back(c);
      c = next_lfsr(c);
    end
    e.resp    = model_resp(s, mode, m);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit noisy);
    bit seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        seed  = $urandom;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    check("idle_after_ack", {62'd0, busy, resp_valid}, 0);
  endtask

  // Monitor: pops expectations whenever the DUT launches a race or presents a response.
  logic la_prev, rv_prev;
  int   hi_run, low_run;

  always @(negedge clk) begin
    if (rst) begin
      la_prev = 1'b0;
      rv_prev = 1'b0;
      hi_run  = 0;
      low_run = 0;
    end else begin
      if (resp_valid && !rv_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("response", response, e.resp);
          check("latency", cyc - e.acc_cyc, LAT);
        end
      end
      if (launch) begin
        if (!la_prev) begin
          check("launch_while_busy", busy, 1);
          if (chal_q.size() == 0) check("unexpected_launch", 1, 0);
          else check("challenge", challenge, chal_q.pop_front());
          // LOAD or SAMPLE contributes one low cycle ahead of the precharge phase.
          check("low_before_launch", low_run, ST + 1);
          hi_run = 0;
        end
        hi_run++;
        low_run = 0;
      end else begin
        if (la_prev && busy) check("launch_width", hi_run, ST);
        hi_run = 0;
        if (busy) low_run++;
        else low_run = 0;
      end
      rv_prev = resp_valid;
      la_prev = launch;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] r_exp;
    int            lr;
    logic          lp;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    resp_ack = 1'b0;
    seed     = '0;
    arb_mode = 0;
    arb_mask = '0;
    #12;
    check("rst_challenge", challenge, 0);
    check("rst_launch", launch, 0);
    check("rst_busy", busy, 0);
    check("rst_response", response, 0);
    check("rst_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Zero seed, constant-one arbiter: known challenge sequence and all-ones response.
    do_start('0, 0, '0);
    check("chal0", challenge, 32'h1);
    repeat (18) @(negedge clk);
    check("chal1", challenge, 32'h3);
    repeat (17) @(negedge clk);
    check("chal2", challenge, 32'h6);
    wait_done(1'b0);
    check("ones_response", response, 16'hFFFF);
    do_ack();

    // Arbiter follows challenge bit 0.
    do_start($urandom, 1, '0);
    wait_done(1'b0);
    do_ack();

    // Start pulses mid-run with a different seed must not disturb the run.
    do_start(32'hA5A5_1234, 2, 32'h0F0F_3C3C);
    repeat (3) @(negedge clk);
    seed  = 32'h1111_2222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (94) @(negedge clk);
    seed  = 32'h3333_4444;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);
    do_ack();

    // Abort in the third race phase.
    do_start($urandom, 1, '0);
    lr = 0;
    lp = 1'b0;
    for (int i = 0; i < LAT && lr < 3; i++) begin
      @(negedge clk);
      if (launch && !lp) lr++;
      lp = launch;
    end
    check("third_race_reached", lr, 3);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_launch", launch, 0);
    check("abort_resp_valid", resp_valid, 0);
    chal_q.delete();
    sb_q.delete();
    repeat (20) @(negedge clk);
    check("abort_stays_idle", {62'd0, busy, resp_valid}, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    do_start($urandom, 2, $urandom);
    wait_done(1'b0);
    do_ack();

    // Hold the response in DONE; abort there is ignored; ack with start returns to idle only.
    arb_mask = $urandom;
    r_exp = model_resp(32'hDEAD_BEEF, 2, arb_mask);
    do_start(32'hDEAD_BEEF, 2, arb_mask);
    wait_done(1'b0);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) abort = 1'b1;
      if (i == 11) abort = 1'b0;
      @(negedge clk);
      check("done_hold_response", response, r_exp);
      check("done_hold_valid", resp_valid, 1);
    end
    resp_ack = 1'b1;
    start    = 1'b1;
    seed     = $urandom;
    @(negedge clk);
    resp_ack = 1'b0;
    start    = 1'b0;
    check("ack_start_valid", resp_valid, 0);
    repeat (5) @(negedge clk);
    check("ack_start_no_run", busy, 0);

    // Randomized runs with start noise while busy.
    for (int n = 0; n < 6; n++) begin
      do_start($urandom, int'($urandom_range(0, 2)), $urandom);
      wait_done(1'b1);
      do_ack();
    end

    // Asynchronous reset in the middle of a race phase.
    do_start($urandom, 1, '0);
    lp = 1'b0;
    for (int i = 0; i < 40 && !lp; i++) begin
      @(negedge clk);
      lp = launch;
    end
    check("race_before_reset", lp, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_launch", launch, 0);
    check("arst_busy", busy, 0);
    check("arst_challenge", challenge, 0);
    check("arst_response", response, 0);
    check("arst_resp_valid", resp_valid, 0);
    chal_q.delete();
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_idle", {62'd0, busy, launch}, 0);
    do_start($urandom, 2, $urandom);
    wait_done(1'b0);
    do_ack();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
